// File: rtl/point_fifo_drain_sched.sv
// point_fifo_drain_sched: round-robin read scheduler for per-lane NTT->DMA point FIFOs
module point_fifo_drain_sched #(
   parameter int NLANE             = 16,
   parameter int COARSE_W          = 4,
   parameter int FIFO_COARSE_DEPTH = 8,
   parameter int SYNC_STAGES       = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic [NLANE*COARSE_W-1:0]   wcoarse_i,
   output logic [NLANE*COARSE_W-1:0]   rcoarse_o,
   output logic                        req_valid_o,
   input  logic                        req_ready_i,
   output logic [$clog2(NLANE)-1:0]    req_lane_o,
   output logic [COARSE_W-2:0]         req_block_o,
   input  logic                        done_i,
   output logic                        busy_o,
   output logic                        err_overflow_o,
   output logic                        err_protocol_o
);
   localparam int LW = $clog2(NLANE);
   localparam logic [COARSE_W:0] DEPTH = (COARSE_W+1)'(FIFO_COARSE_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e                                       state_q, state_d;
   logic [SYNC_STAGES-1:0][NLANE-1:0][COARSE_W-1:0] sync_q;
   logic [NLANE-1:0][COARSE_W-1:0]                wbin_q, wbin_d, rptr_q, rptr_d, rcoarse_q, rcoarse_d, fill;
   logic [NLANE-1:0]                              avail;
   logic [LW-1:0]                                 rr_q, rr_d, lane_q, lane_d, sel;
   logic [COARSE_W-2:0]                           blk_q, blk_d;
   logic                                          ovf_q, ovf_d, prot_q, prot_d, found, ovf;

   function automatic logic [COARSE_W-1:0] g2b(input logic [COARSE_W-1:0] g);
      logic [COARSE_W-1:0] b;
      b[COARSE_W-1] = g[COARSE_W-1];
      for (int i = COARSE_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [COARSE_W-1:0] b2g(input logic [COARSE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   always_comb begin
      wbin_d = '0;
      fill   = '0;
      avail  = '0;
      ovf    = 1'b0;
      for (int l = 0; l < NLANE; l++) begin
         wbin_d[l] = g2b(sync_q[SYNC_STAGES-1][l]);
         fill[l]   = wbin_q[l] - rptr_q[l];
         avail[l]  = fill[l] != '0;
         ovf       = ovf | ({1'b0, fill[l]} > DEPTH);
      end
   end

   // first available lane at or above rr, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NLANE; i++)
         if (!found && avail[rr_q + LW'(i)]) begin
            found = 1'b1;
            sel   = rr_q + LW'(i);
         end
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      blk_d     = blk_q;
      rr_d      = rr_q;
      rptr_d    = rptr_q;
      rcoarse_d = rcoarse_q;
      ovf_d     = ovf_q | ovf;
      prot_d    = prot_q | (done_i && state_q != WAIT);
      case (state_q)
         IDLE: if (enable_i && found) begin
            lane_d  = sel;
            blk_d   = rptr_q[sel][COARSE_W-2:0];
            state_d = REQ;
         end
         REQ:  if (req_ready_i) state_d = WAIT;
         WAIT: if (done_i) begin
            rptr_d[lane_q]    = rptr_q[lane_q] + COARSE_W'(1);
            rcoarse_d[lane_q] = b2g(rptr_d[lane_q]);
            rr_d              = lane_q + LW'(1);
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         wbin_q    <= '0;
         rptr_q    <= '0;
         rcoarse_q <= '0;
         rr_q      <= '0;
         lane_q    <= '0;
         blk_q     <= '0;
         ovf_q     <= 1'b0;
         prot_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], wcoarse_i};
         wbin_q    <= wbin_d;
         rptr_q    <= rptr_d;
         rcoarse_q <= rcoarse_d;
         rr_q      <= rr_d;
         lane_q    <= lane_d;
         blk_q     <= blk_d;
         ovf_q     <= ovf_d;
         prot_q    <= prot_d;
      end
   end

   assign rcoarse_o      = rcoarse_q;
   assign req_valid_o    = state_q == REQ;
   assign req_lane_o     = lane_q;
   assign req_block_o    = blk_q;
   assign busy_o         = state_q != IDLE;
   assign err_overflow_o = ovf_q;
   assign err_protocol_o = prot_q;
endmodule

// File: tb/tb_point_fifo_drain_sched.sv
// tb_point_fifo_drain_sched: scoreboard bench for the point FIFO drain scheduler
module tb_point_fifo_drain_sched;
   localparam int NL = 16, CW = 4, SS = 2;

   logic clk = 0, rst_n = 0, enable = 0, req_ready = 0, done = 0;
   logic [NL*CW-1:0] wcoarse = '0, rcoarse;
   logic req_valid, busy, err_ovf, err_prot;
   logic [3:0] req_lane;
   logic [2:0] req_block;
   int checks = 0, errors = 0;
   int rmod[NL];

   typedef struct {int lane; int blk;} exp_t;
   exp_t sbq[$];

   point_fifo_drain_sched dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .wcoarse_i(wcoarse),
      .rcoarse_o(rcoarse), .req_valid_o(req_valid), .req_ready_i(req_ready),
      .req_lane_o(req_lane), .req_block_o(req_block), .done_i(done), .busy_o(busy),
      .err_overflow_o(err_ovf), .err_protocol_o(err_prot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] gray(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [63:0] rc_exp();
      logic [63:0] r;
      r = '0;
      for (int l = 0; l < NL; l++) r[l*CW +: CW] = gray(rmod[l]);
      return r;
   endfunction

   task automatic set_w(input int l, input int b);
      wcoarse[l*CW +: CW] = gray(b);
   endtask

   task automatic push(input int l, input int b);
      exp_t e;
      e.lane = l;
      e.blk  = b;
      sbq.push_back(e);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic idle_cycles(input int c, output int seen);
      seen = 0;
      for (int i = 0; i < c; i++) begin
         @(negedge clk);
         if (req_valid) seen++;
      end
   endtask

   task automatic serve(input int stall, input bit drop_en);
      int n;
      exp_t e;
      wait_valid(n);
      chk("req_seen", req_valid, 1);
      if (!req_valid) return;
      if (sbq.size() == 0) begin
         chk("sb_nonempty", sbq.size(), 1);
         return;
      end
      e = sbq.pop_front();
      chk("lane", req_lane, e.lane);
      chk("block", req_block, e.blk);
      chk("busy_req", busy, 1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", req_valid, 1);
         chk("stall_lane", req_lane, e.lane);
         chk("stall_block", req_block, e.blk);
      end
      req_ready = 1;
      @(negedge clk);
      req_ready = 0;
      chk("valid_drop", req_valid, 0);
      chk("busy_wait", busy, 1);
      if (drop_en) enable = 0;
      repeat (2) @(negedge clk);
      done = 1;
      @(negedge clk);
      done = 0;
      rmod[e.lane] = (rmod[e.lane] + 1) % 16;
      chk("rcoarse", rcoarse, rc_exp());
      chk("idle_gap", req_valid, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, seen;
      for (int l = 0; l < NL; l++) rmod[l] = 0;
      enable = 1;
      repeat (3) @(negedge clk);
      chk("rst_valid", req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rcoarse", rcoarse, 0);
      chk("rst_ovf", err_ovf, 0);
      chk("rst_prot", err_prot, 0);
      rst_n = 1;

      // round robin across lanes 2, 9, 14 with two blocks each
      set_w(2, 2); set_w(9, 2); set_w(14, 2);
      push(2, 0); push(9, 0); push(14, 0); push(2, 1); push(9, 1); push(14, 1);
      for (int k = 0; k < 6; k++) serve(0, 0);
      chk("rr_rc2", rcoarse[2*CW +: CW], 3);
      chk("rr_rc9", rcoarse[9*CW +: CW], 3);
      chk("rr_rc14", rcoarse[14*CW +: CW], 3);

      // asynchronous reset while lane 3 is requesting
      set_w(3, 1);
      wait_valid(n);
      chk("pre_rst_lane", req_lane, 3);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", req_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rcoarse", rcoarse, 0);
      chk("arst_errs", {err_ovf, err_prot}, 0);
      wcoarse = '0;
      for (int l = 0; l < NL; l++) rmod[l] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      idle_cycles(10, seen);
      chk("no_grant_after_rst", seen, 0);

      // single lane latency
      set_w(5, 1);
      wait_valid(n);
      chk("latency", n, SS + 2);
      push(5, 0);
      serve(0, 0);
      chk("rc5", rcoarse[5*CW +: CW], 1);
      idle_cycles(10, seen);
      chk("single_no_more", seen, 0);

      // stall and enable drop
      set_w(7, 2);
      push(7, 0);
      serve(10, 1);
      idle_cycles(10, seen);
      chk("disabled_no_req", seen, 0);
      enable = 1;
      push(7, 1);
      serve(0, 0);

      // lane 0 pointer walk to 15, then wrap
      for (int k = 0; k < 15; k++) begin
         set_w(0, k + 1);
         push(0, k % 8);
         serve(0, 0);
      end
      set_w(0, 1);
      push(0, 7); push(0, 0);
      serve(0, 0);
      serve(0, 0);
      chk("wrap_rc0", rcoarse[0 +: CW], 1);
      chk("ovf_clear", err_ovf, 0);

      // fill 8 is legal, fill 9 overflows
      set_w(0, 9);
      repeat (6) @(negedge clk);
      chk("fill8_ok", err_ovf, 0);
      set_w(0, 10);
      repeat (6) @(negedge clk);
      chk("fill9_ovf", err_ovf, 1);
      set_w(0, 2);
      repeat (6) @(negedge clk);
      chk("ovf_sticky", err_ovf, 1);
      push(0, 1);
      serve(0, 0);

      // done pulse while idle
      repeat (3) @(negedge clk);
      chk("prot_clear", err_prot, 0);
      done = 1;
      @(negedge clk);
      done = 0;
      chk("prot_set", err_prot, 1);
      chk("prot_rcoarse", rcoarse, rc_exp());
      idle_cycles(5, seen);
      chk("prot_no_req", seen, 0);
      chk("prot_sticky", err_prot, 1);
      chk("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
